// File: rtl/muldiv_ctrl.sv
// Sequencer for the EX-stage multiplier and divider. It latches one mult/multu/div/divu op,
// stalls EX until the result is captured, then holds a HI/LO write until EX advances.
module muldiv_ctrl #(
  parameter int MUL_LAT     = 1,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_mult,
  input  logic        op_multu,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ex_advance,
  input  logic        flush,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy,
  output logic        div_err
);

  localparam int CNT_MAX = (DIV_TIMEOUT > MUL_LAT) ? DIV_TIMEOUT : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL_WAIT, S_DIV_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {K_MULT, K_MULTU, K_DIV, K_DIVU} kind_t;

  state_t          r_state, w_next_state;
  kind_t           r_kind, w_kind;
  logic [31:0]     r_op1, r_op2, r_hi, r_lo;
  logic [CW-1:0]   r_cnt;
  logic            r_div_err;

  logic w_any_op, w_accept, w_kind_is_div, w_src2_zero, w_cnt_zero, w_timeout, w_abort;

  // Decode priority: div > divu > mult > multu.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_kind = K_MULTU;
    if (op_div)        w_kind = K_DIV;
    else if (op_divu)  w_kind = K_DIVU;
    else if (op_mult)  w_kind = K_MULT;
  end

  assign w_any_op      = op_mult | op_multu | op_div | op_divu;
  assign w_accept      = (r_state == S_IDLE) && w_any_op && !flush;
  assign w_kind_is_div = (w_kind == K_DIV) || (w_kind == K_DIVU);
  assign w_src2_zero   = (src2 == 32'd0);
  assign w_cnt_zero    = (r_cnt == '0);
  // A ready divider wins over a timeout landing in the same cycle.
  assign w_timeout     = (r_state == S_DIV_RUN) && !div_ready && (r_cnt == CW'(DIV_TIMEOUT - 1));
  assign w_abort       = (r_state == S_DIV_RUN) && (flush || w_timeout);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any_op) begin
            if (!w_kind_is_div)   w_next_state = S_MUL_WAIT;
            else if (w_src2_zero) w_next_state = S_DONE;
            else                  w_next_state = S_DIV_RUN;
          end
        end
        S_MUL_WAIT: if (w_cnt_zero) w_next_state = S_DONE;
        S_DIV_RUN: begin
          if (div_ready)      w_next_state = S_DONE;
          else if (w_timeout) w_next_state = S_IDLE;
        end
        S_DONE: if (ex_advance) w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Operand, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1     <= '0;
      r_op2     <= '0;
      r_kind    <= K_MULT;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_div_err <= 1'b0;
    end else if (!flush) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op1  <= src1;
            r_op2  <= src2;
            r_kind <= w_kind;
            r_cnt  <= w_kind_is_div ? '0 : CW'(MUL_LAT - 1);
            if (w_kind_is_div && w_src2_zero) begin
              r_hi <= src1;
              r_lo <= 32'hFFFF_FFFF;
            end
          end
        end
        S_MUL_WAIT: begin
          if (w_cnt_zero) {r_hi, r_lo} <= mul_result;
          else            r_cnt <= r_cnt - 1'b1;
        end
        S_DIV_RUN: begin
          if (div_ready) begin
            {r_hi, r_lo} <= div_result;
          end else begin
            if (r_cnt != CW'(CNT_MAX)) r_cnt <= r_cnt + 1'b1;
            if (w_timeout)             r_div_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    mul_signed = 1'b0;
    mul_ina    = '0;
    mul_inb    = '0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_op1    = '0;
    div_op2    = '0;
    div_annul  = 1'b0;
    stallreq   = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stallreq   = 1'b1;
          mul_ina    = src1;
          mul_inb    = src2;
          mul_signed = (w_kind == K_MULT);
        end
      end
      S_MUL_WAIT: begin
        stallreq   = !flush;
        mul_ina    = r_op1;
        mul_inb    = r_op2;
        mul_signed = (r_kind == K_MULT);
      end
      S_DIV_RUN: begin
        stallreq   = !w_abort;
        div_op1    = r_op1;
        div_op2    = r_op2;
        div_signed = (r_kind == K_DIV);
        div_start  = !div_ready && !w_abort;
        div_annul  = w_abort;
      end
      S_DONE: begin
        if (!flush) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_o  = r_hi;
          lo_o  = r_lo;
        end
      end
      default: ;
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign div_err = r_div_err;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: models a pipelined multiplier and a fixed-latency divider,
// runs a vector table through a result scoreboard, then flush/timeout/reset sequences.
module tb_muldiv_ctrl;

  localparam int MUL_LAT     = 1;
  localparam int DIV_TIMEOUT = 64;
  localparam int DIV_READY_AT = 32;  // divider asserts ready on its 33rd run cycle

  logic        clk = 1'b0;
  logic        rst;
  logic        op_mult, op_multu, op_div, op_divu;
  logic [31:0] src1, src2;
  logic        ex_advance, flush;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed;
  logic [31:0] div_op1, div_op2;
  logic        div_annul, div_ready;
  logic [63:0] div_result;
  logic        stallreq, hi_we, lo_we;
  logic [31:0] hi_o, lo_o;
  logic        busy, div_err;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .src1(src1), .src2(src2), .ex_advance(ex_advance), .flush(flush),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_op1(div_op1), .div_op2(div_op2),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .stallreq(stallreq), .hi_we(hi_we), .lo_we(lo_we), .hi_o(hi_o), .lo_o(lo_o),
    .busy(busy), .div_err(div_err)
  );

  // Multiplier model: product of the sampled operands appears MUL_LAT cycles later.
  logic [63:0] mul_pipe [MUL_LAT];
  logic [63:0] w_prod;
  always_comb begin
    if (mul_signed) w_prod = $signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb});
    else            w_prod = {32'b0, mul_ina} * {32'b0, mul_inb};
  end
  always @(posedge clk) begin
    mul_pipe[0] <= w_prod;
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_result = mul_pipe[MUL_LAT-1];

  // Divider model: ready after DIV_READY_AT consecutive start cycles, unless told to hang.
  logic [7:0] div_cnt = '0;
  logic       div_never = 1'b0;
  always @(posedge clk) div_cnt <= div_start ? div_cnt + 8'd1 : 8'd0;
  assign div_ready = !div_never && (div_cnt == 8'(DIV_READY_AT));
  always_comb begin
    div_result = '0;
    if (div_op2 != 0) begin
      if (div_signed) div_result = {32'($signed(div_op1) % $signed(div_op2)), 32'($signed(div_op1) / $signed(div_op2))};
      else            div_result = {div_op1 % div_op2, div_op1 / div_op2};
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  ops;     // {mult, multu, div, divu}
    logic [31:0] a, b;
    int          hold;    // extra DONE cycles with ex_advance low
    logic [31:0] hi, lo;
    int          stalls;
    int          starts;
  } vec_t;

  logic [63:0] sb_q[$];

  task automatic set_ops(input logic [3:0] ops);
    {op_mult, op_multu, op_div, op_divu} = ops;
  endtask

  task automatic run_vec(input vec_t v);
    int stalls, starts, cyc;
    logic [63:0] exp;
    @(negedge clk);
    set_ops(v.ops); src1 = v.a; src2 = v.b;
    sb_q.push_back({v.hi, v.lo});
    #1;
    stalls = int'(stallreq);
    starts = int'(div_start);
    cyc = 0;
    @(negedge clk); set_ops(4'b0); #1;
    while (!hi_we && cyc < 200) begin
      stalls += int'(stallreq);
      starts += int'(div_start);
      cyc++;
      @(negedge clk); #1;
    end
    check("reach_done", {63'b0, hi_we}, 64'd1);
    exp = sb_q.pop_front();
    if (!hi_we) return;
    check("hi_o", {32'b0, hi_o}, {32'b0, exp[63:32]});
    check("lo_o", {32'b0, lo_o}, {32'b0, exp[31:0]});
    check("lo_we", {63'b0, lo_we}, 64'd1);
    check("stall_cycles", 64'(stalls), 64'(v.stalls));
    check("start_cycles", 64'(starts), 64'(v.starts));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk); #1;
      check("hold_we", {62'b0, hi_we, lo_we}, 64'd3);
      check("hold_data", {hi_o, lo_o}, exp);
    end
    check("done_unstalled", {63'b0, stallreq}, 64'd0);
    ex_advance = 1'b1;
    @(negedge clk); ex_advance = 1'b0; #1;
    check("idle_after_adv", {62'b0, busy, hi_we}, 64'd0);
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); op_div = 1'b1; src1 = a; src2 = b; #1;
    @(negedge clk); op_div = 1'b0; #1;  // now in run cycle 1
  endtask

  logic outs_any;
  assign outs_any = |{mul_signed, mul_ina, mul_inb, div_start, div_signed, div_op1, div_op2,
                      div_annul, stallreq, hi_we, lo_we, hi_o, lo_o, busy, div_err};

  vec_t vecs [11];
  int   run;

  initial begin
    vecs[0]  = '{4'b1000, 32'hFFFF_FFFD, 32'd5,        0, 32'hFFFF_FFFF, 32'hFFFF_FFF1,  2,  0};
    vecs[1]  = '{4'b0100, 32'hFFFF_FFFF, 32'd2,        3, 32'h0000_0001, 32'hFFFF_FFFE,  2,  0};
    vecs[2]  = '{4'b0010, 32'hFFFF_FFF9, 32'd2,        0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 32};
    vecs[3]  = '{4'b0001, 32'd1234,      32'd0,        0, 32'd1234,      32'hFFFF_FFFF,  1,  0};
    vecs[4]  = '{4'b0001, 32'd100,       32'd7,        1, 32'd2,         32'd14,        34, 32};
    vecs[5]  = '{4'b1000, 32'h0001_0000, 32'h0001_0000, 0, 32'h0000_0001, 32'h0000_0000, 2,  0};
    vecs[6]  = '{4'b0010, 32'd7,         32'hFFFF_FFFE, 0, 32'd1,         32'hFFFF_FFFD, 34, 32};
    vecs[7]  = '{4'b0010, 32'hFFFF_FFF0, 32'd0,        0, 32'hFFFF_FFF0, 32'hFFFF_FFFF,  1,  0};
    vecs[8]  = '{4'b1010, 32'd20,        32'd3,        0, 32'd2,         32'd6,         34, 32};
    vecs[9]  = '{4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0,        32'd1,          2,  0};
    vecs[10] = '{4'b1001, 32'h8000_0000, 32'd3,        0, 32'd2,         32'h2AAA_AAAA, 34, 32};

    rst = 1'b1; set_ops(4'b0); src1 = '0; src2 = '0; ex_advance = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {63'b0, outs_any}, 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_after_reset", {62'b0, busy, stallreq}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush in the acceptance cycle: nothing is accepted.
    @(negedge clk); op_mult = 1'b1; src1 = 32'd3; src2 = 32'd4; flush = 1'b1; #1;
    check("flush_accept_stall", {31'b0, stallreq, mul_ina}, 64'd0);
    @(negedge clk); op_mult = 1'b0; flush = 1'b0; #1;
    check("flush_accept_idle", {63'b0, busy}, 64'd0);

    // Flush in DIV_RUN cycle 10: one annul pulse, no write, then a normal mult.
    start_div(32'd100, 32'd7);
    for (int r = 1; r < 10; r++) begin @(negedge clk); #1; end
    check("div_running", {62'b0, busy, div_start}, 64'd3);
    flush = 1'b1; #1;
    check("flush_annul", {60'b0, div_annul, div_start, stallreq, hi_we}, 64'b1000);
    @(negedge clk); flush = 1'b0; #1;
    check("flush_after", {61'b0, div_annul, busy, hi_we}, 64'd0);
    run_vec(vecs[0]);

    // Divider never ready: forced abort on run cycle DIV_TIMEOUT, sticky error.
    div_never = 1'b1;
    start_div(32'd5, 32'd1);
    run = 1;
    while (!div_annul && run < 200) begin @(negedge clk); #1; run++; end
    check("timeout_cycle", 64'(run), 64'(DIV_TIMEOUT));
    check("timeout_outs", {61'b0, div_start, stallreq, hi_we}, 64'd0);
    @(negedge clk); #1;
    check("timeout_after", {61'b0, busy, div_err, div_annul}, 64'b010);
    repeat (5) @(negedge clk);
    #1;
    check("div_err_sticky", {63'b0, div_err}, 64'd1);

    // Reset in the middle of DIV_RUN clears everything.
    start_div(32'd9, 32'd3);
    repeat (4) @(negedge clk);
    #1;
    check("run_before_rst", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_run", {63'b0, outs_any}, 64'd0);
    rst = 1'b0; div_never = 1'b0;
    run_vec(vecs[4]);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
